// File: rtl/key_matrix_scan_if.sv
// Keypad pin and event bundle for key_matrix_scan.
// master: the scanner (drives rows and key events, senses columns).
// slave:  the keypad/consumer side (senses rows and events, drives columns).
interface key_matrix_scan_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = 4
);
  logic [ROWS-1:0]      row_out;
  logic [COLS-1:0]      col_in;
  logic [ROWS*COLS-1:0] key_state;
  logic                 key_press;
  logic                 key_release;
  logic [CODE_W-1:0]    key_code;

  modport master (
    output row_out, key_state, key_press, key_release, key_code,
    input  col_in
  );

  modport slave (
    input  row_out, key_state, key_press, key_release, key_code,
    output col_in
  );
endinterface

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: row-strobed 4x4 keypad scanner with whole-frame debouncing.
// Each row is driven low for SCAN_DIV cycles; its columns are snapshotted at the
// end of the slot. After the last row one EVAL cycle compares the frame snapshot
// with the previous one; DEB_CNT+1 identical frames commit a new key_state and
// emit one press/release pulse for the lowest changed key.
// Optional build macro KEY_GHOST_REJECT_EN: frames with more than two pressed
// keys are treated as mismatches and never committed.
module key_matrix_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int CODE_W   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEB_CNT  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  key_matrix_scan_if.master kbd
);
  localparam int KEYS  = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEB_CNT);

  typedef enum logic {DRIVE, EVAL} state_t;

  state_t              state_reg;
  logic [ROW_W-1:0]    row_reg;
  logic [DIV_W-1:0]    div_reg;
  logic [STB_W-1:0]    stable_reg;
  logic [KEYS-1:0]     snap_reg;
  logic [KEYS-1:0]     ref_reg;
  logic [KEYS-1:0]     key_state_reg;
  logic [ROWS-1:0]     row_out_reg;
  logic                key_press_reg;
  logic                key_release_reg;
  logic [CODE_W-1:0]   key_code_reg;
  logic [COLS-1:0]     col_meta_reg;
  logic [COLS-1:0]     col_sync_reg;

  logic [ROWS-1:0]     row_cold;
  logic [ROWS-1:0]     next_row_cold;
  logic                ghost;
  logic                frame_match;
  logic [STB_W-1:0]    stable_next;
  logic [KEYS-1:0]     ref_next;
  logic [KEYS-1:0]     diff;
  logic                commit;
  logic [CODE_W-1:0]   first_code;
  logic                first_rise;

  // Two-flop synchroniser for the asynchronous, active-low column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_reg <= '1;
      col_sync_reg <= '1;
    end else begin
      col_meta_reg <= kbd.col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  // One-cold row patterns for the current row and the row that follows it.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_cold[gi]      = (row_reg != ROW_W'(gi));
    assign next_row_cold[gi] = ((row_reg + ROW_W'(1)) != ROW_W'(gi));
  end

`ifdef KEY_GHOST_REJECT_EN
  localparam int CNT_W = $clog2(KEYS + 1);
  logic [CNT_W-1:0] pressed_cnt;

  // Count pressed keys in the frame; three or more may include phantom keys.
  always_comb begin
    pressed_cnt = '0;
    for (int i = 0; i < KEYS; i++) begin
      pressed_cnt = pressed_cnt + CNT_W'(snap_reg[i]);
    end
  end
  assign ghost = (pressed_cnt > CNT_W'(2));
`else
  assign ghost = 1'b0;
`endif

  assign frame_match = (snap_reg == ref_reg) && !ghost;

  // Debounce update: count identical frames, or restart on any difference.
  // A rejected (ghost) frame restarts the count but keeps the old reference.
  always_comb begin
    stable_next = '0;
    ref_next    = ref_reg;
    if (frame_match) begin
      stable_next = (stable_reg == STB_MAX) ? stable_reg : stable_reg + STB_W'(1);
    end else if (!ghost) begin
      ref_next = snap_reg;
    end
  end

  assign diff   = ref_next ^ key_state_reg;
  assign commit = (stable_next == STB_MAX) && (ref_next != key_state_reg);

  // Lowest changed key index and its new level; descending scan so the lowest wins.
  always_comb begin
    first_code = '0;
    first_rise = 1'b0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (diff[i]) begin
        first_code = CODE_W'(i);
        first_rise = ref_next[i];
      end
    end
  end

  // Scan FSM: strobe rows, snapshot columns, evaluate and commit once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= DRIVE;
      row_reg         <= '0;
      div_reg         <= '0;
      stable_reg      <= '0;
      snap_reg        <= '0;
      ref_reg         <= '0;
      key_state_reg   <= '0;
      row_out_reg     <= '1;
      key_press_reg   <= 1'b0;
      key_release_reg <= 1'b0;
      key_code_reg    <= '0;
    end else begin
      key_press_reg   <= 1'b0;
      key_release_reg <= 1'b0;
      case (state_reg)
        DRIVE: begin
          row_out_reg <= row_cold;
          if (div_reg == LAST_DIV) begin
            snap_reg[int'(row_reg)*COLS +: COLS] <= ~col_sync_reg;
            div_reg <= '0;
            if (row_reg == LAST_ROW) begin
              state_reg   <= EVAL;
              row_out_reg <= '1;
            end else begin
              row_reg     <= row_reg + ROW_W'(1);
              row_out_reg <= next_row_cold;
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        EVAL: begin
          stable_reg  <= stable_next;
          ref_reg     <= ref_next;
          row_reg     <= '0;
          div_reg     <= '0;
          row_out_reg <= ~ROWS'(1);
          state_reg   <= DRIVE;
          if (commit) begin
            key_state_reg   <= ref_next;
            key_code_reg    <= first_code;
            key_press_reg   <= first_rise;
            key_release_reg <= !first_rise;
          end
        end
        default: state_reg <= DRIVE;
      endcase
    end
  end

  assign kbd.row_out     = row_out_reg;
  assign kbd.key_state   = key_state_reg;
  assign kbd.key_press   = key_press_reg;
  assign kbd.key_release = key_release_reg;
  assign kbd.key_code    = key_code_reg;

endmodule
